// File: rtl/regfile_host_bridge.sv
// Byte-serial host command bridge into a register file: write strobes, combinational
// read addressing, a valid/ready response stream, and a full-register dump.
module regfile_host_bridge #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         OutValid,
    output logic [W-1:0] OutData,
    input  logic         OutReady,
    output logic         RfWriteEn,
    output logic [D-1:0] RfWaddr,
    output logic [W-1:0] RfWdata,
    output logic [D-1:0] RfRaddr,
    input  logic [W-1:0] RfRdata,
    output logic         CmdErr,
    output logic         Busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        READ,
        RESP,
        DUMP_LOAD,
        DUMP_SEND
    } state_t;

    localparam logic [1:0]   OP_READ  = 2'b00;
    localparam logic [1:0]   OP_DUMP  = 2'b01;
    localparam logic [1:0]   OP_WRITE = 2'b10;
    localparam logic [D-1:0] CNT_LAST = '1;

    state_t       state;
    state_t       state_nxt;
    logic [D-1:0] addr_q;
    logic [D-1:0] cnt_q;
    logic [W-1:0] data_q;
    logic [W-1:0] out_q;
    logic         err_q;
    logic         in_hs;
    logic         out_hs;
    logic [1:0]   op;

    // Only the opcode and address bits of a command carry meaning.
    logic unused_in;
    assign unused_in = ^InData;

    assign op     = InData[7:6];
    assign in_hs  = InValid && InReady;
    assign out_hs = OutValid && OutReady;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    case (op)
                        OP_WRITE: state_nxt = GET_DATA;
                        OP_READ:  state_nxt = READ;
                        OP_DUMP:  state_nxt = DUMP_LOAD;
                        default:  state_nxt = IDLE;
                    endcase
                end
            end
            GET_DATA:  if (in_hs) state_nxt = WRITE;
            WRITE:     state_nxt = IDLE;
            READ:      state_nxt = RESP;
            RESP:      if (out_hs) state_nxt = IDLE;
            DUMP_LOAD: state_nxt = DUMP_SEND;
            DUMP_SEND: begin
                if (out_hs) begin
                    state_nxt = (cnt_q == CNT_LAST) ? IDLE : DUMP_LOAD;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Latched command fields, dump counter and the registered response byte.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && in_hs && (op == 2'b11);
            if ((state == IDLE) && in_hs) begin
                addr_q <= InData[D-1:0];
                if (op == OP_DUMP) begin
                    cnt_q <= '0;
                end
            end
            if ((state == GET_DATA) && in_hs) begin
                data_q <= InData;
            end
            if ((state == READ) || (state == DUMP_LOAD)) begin
                out_q <= RfRdata;
            end
            if ((state == DUMP_SEND) && out_hs && (cnt_q != CNT_LAST)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        InReady   = 1'b0;
        OutValid  = 1'b0;
        RfWriteEn = 1'b0;
        RfRaddr   = addr_q;
        case (state)
            IDLE:      InReady = 1'b1;
            GET_DATA:  InReady = 1'b1;
            WRITE:     RfWriteEn = 1'b1;
            RESP:      OutValid = 1'b1;
            DUMP_LOAD: RfRaddr = cnt_q;
            DUMP_SEND: OutValid = 1'b1;
            default:   InReady = 1'b0;
        endcase
    end

    assign OutData = out_q;
    assign RfWaddr = addr_q;
    assign RfWdata = data_q;
    assign CmdErr  = err_q;
    assign Busy    = (state != IDLE);

endmodule
